// File: rtl/rf_scoreboard.sv
// Decode-stage register file with write-first bypass, per-register
// busy scoreboard and a post-reset clear sequencer.
module rf_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              busy1,
    output logic              busy2,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              flush,
    output logic              ready
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] CLR_FIRST = ADDR_W'(ZERO_REG != 0 ? 1 : 0);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] clr_idx;
    logic [ADDR_W-1:0] clr_idx_nx;
    logic [DATA_W-1:0] rf [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nx;
    logic              run;
    logic              wr_en;

    assign run   = (state == RUN);
    assign ready = run;
    assign wr_en = run && we && !(ZERO_REG != 0 && waddr == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= CLR_FIRST;
        end else begin
            state   <= state_nx;
            clr_idx <= clr_idx_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        clr_idx_nx = clr_idx;
        if (state == CLEAR) begin
            clr_idx_nx = clr_idx + 1'b1;
            if (clr_idx == CLR_LAST) state_nx = RUN;
        end
    end

    // Array deliberately has no reset; the sequencer zeroes it instead.
    always_ff @(posedge clk) begin
        if (!run) begin
            rf[clr_idx] <= '0;
        end else if (wr_en) begin
            rf[waddr] <= wdata;
        end
    end

    // A new producer on the same register outranks the retiring one.
    always_comb begin
        busy_nx = busy;
        if (run) begin
            if (flush) begin
                busy_nx = '0;
            end else begin
                if (we) busy_nx[waddr] = 1'b0;
                if (issue_en) busy_nx[issue_addr] = 1'b1;
            end
        end
        if (ZERO_REG != 0) busy_nx[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else busy <= busy_nx;
    end

    function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] a);
        if (!run) return '0;
        if (ZERO_REG != 0 && a == '0) return '0;
        if (we && waddr == a) return wdata;
        return rf[a];
    endfunction

    function automatic logic rd_busy(input logic [ADDR_W-1:0] a);
        return run && busy[a] && !(we && waddr == a);
    endfunction

    assign rdata1 = rd_val(raddr1);
    assign rdata2 = rd_val(raddr2);
    assign busy1  = rd_busy(raddr1);
    assign busy2  = rd_busy(raddr2);

endmodule

// File: tb/tb_rf_scoreboard.sv
// Bench for rf_scoreboard: runs ZERO_REG=1 and ZERO_REG=0 instances
// side by side against a per-register reference model.
module tb_rf_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [4:0]  raddr1 = '0;
    logic [4:0]  raddr2 = '0;
    logic        issue_en = 1'b0;
    logic [4:0]  issue_addr = '0;
    logic        flush = 1'b0;

    logic [31:0] rd1 [2];
    logic [31:0] rd2 [2];
    logic        bs1 [2];
    logic        bs2 [2];
    logic        rdy [2];

    int checks = 0;
    int errors = 0;

    // Model: index 1 = ZERO_REG=1 instance, index 0 = ZERO_REG=0 instance
    logic [31:0] mem [2][32];
    bit          bz [2][32];

    always #5 clk = ~clk;

    rf_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut_z (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1[1]), .rdata2(rd2[1]),
        .busy1(bs1[1]), .busy2(bs2[1]), .issue_en(issue_en),
        .issue_addr(issue_addr), .flush(flush), .ready(rdy[1])
    );

    rf_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut_n (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1[0]), .rdata2(rd2[0]),
        .busy1(bs1[0]), .busy2(bs2[0]), .issue_en(issue_en),
        .issue_addr(issue_addr), .flush(flush), .ready(rdy[0])
    );

    function automatic logic [31:0] exp_rd(int z, logic [4:0] a);
        if (z == 1 && a == 0) return 32'h0;
        if (we && waddr == a) return wdata;
        return mem[z][a];
    endfunction

    function automatic bit exp_bs(int z, logic [4:0] a);
        return bz[z][a] && !(we && waddr == a);
    endfunction

    task automatic model_clear();
        for (int z = 0; z < 2; z++)
            for (int a = 0; a < 32; a++) begin
                mem[z][a] = 32'h0;
                bz[z][a] = 1'b0;
            end
    endtask

    task automatic idle();
        we = 1'b0;
        issue_en = 1'b0;
        flush = 1'b0;
    endtask

    // Advance one rising edge and apply the register/scoreboard rules.
    task automatic tick();
        @(posedge clk);
        for (int z = 0; z < 2; z++) begin
            if (we && !(z == 1 && waddr == 0)) mem[z][waddr] = wdata;
            if (flush) begin
                for (int a = 0; a < 32; a++) bz[z][a] = 1'b0;
            end else begin
                if (we) bz[z][waddr] = 1'b0;
                if (issue_en && !(z == 1 && issue_addr == 0))
                    bz[z][issue_addr] = 1'b1;
            end
        end
    endtask

    task automatic wait_clear(output int n1, output int n0);
        n1 = 0;
        n0 = 0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (rdy[1] && n1 == 0) begin n1 = c; idle(); end
            if (rdy[0] && n0 == 0) begin n0 = c; idle(); end
            if (n1 != 0 && n0 != 0) break;
        end
    endtask

    task automatic test_reset();
        int n1, n0;
        #1;
        for (int z = 0; z < 2; z++) begin
            checks++;
            if (rdy[z] !== 1'b0 || rd1[z] !== 32'h0 || bs1[z] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state z=%0d ready=%b rdata1=%h busy1=%b want 0/0/0",
                         z, rdy[z], rd1[z], bs1[z]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        wait_clear(n1, n0);
        model_clear();
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            we = 1'b1;
            waddr = 5'(a);
            wdata = $urandom;
            tick();
        end
        @(negedge clk);
        idle();
        for (int a = 0; a < 32; a += 7) begin
            raddr1 = 5'(a);
            #1;
            for (int z = 0; z < 2; z++) begin
                checks++;
                if (rd1[z] !== exp_rd(z, raddr1)) begin
                    errors++;
                    $display("FAIL garbage_read z=%0d r%0d got %h want %h",
                             z, a, rd1[z], exp_rd(z, raddr1));
                end
            end
        end
        @(negedge clk);
        rst = 1'b1;
        we = 1'b1;
        waddr = 5'd3;
        wdata = 32'hDEAD;
        issue_en = 1'b1;
        issue_addr = 5'd3;
        raddr1 = 5'd3;
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int z = 0; z < 2; z++) begin
            checks++;
            if (rd1[z] !== 32'h0 || bs1[z] !== 1'b0) begin
                errors++;
                $display("FAIL clear_outputs z=%0d rdata1=%h busy1=%b want 0/0",
                         z, rd1[z], bs1[z]);
            end
        end
        wait_clear(n1, n0);
        checks++;
        if (n1 != 31) begin
            errors++;
            $display("FAIL clear_edges_zr1 got %0d want 31", n1);
        end
        checks++;
        if (n0 != 32) begin
            errors++;
            $display("FAIL clear_edges_zr0 got %0d want 32", n0);
        end
        model_clear();
        @(negedge clk);
        idle();
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a);
            raddr2 = 5'(31 - a);
            #1;
            for (int z = 0; z < 2; z++) begin
                checks++;
                if (rd1[z] !== 32'h0 || rd2[z] !== 32'h0 || bs1[z] !== 1'b0) begin
                    errors++;
                    $display("FAIL cleared_read z=%0d r%0d got %h/%h busy %b want 0",
                             z, a, rd1[z], rd2[z], bs1[z]);
                end
            end
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        idle();
        we = 1'b1;
        waddr = 5'd5;
        wdata = 32'h12345678;
        raddr1 = 5'd5;
        raddr2 = 5'd5;
        #1;
        for (int z = 0; z < 2; z++) begin
            checks++;
            if (rd1[z] !== 32'h12345678 || rd2[z] !== 32'h12345678) begin
                errors++;
                $display("FAIL bypass z=%0d got %h/%h want 12345678", z, rd1[z], rd2[z]);
            end
        end
        tick();
        @(negedge clk);
        idle();
        #1;
        for (int z = 0; z < 2; z++) begin
            checks++;
            if (rd1[z] !== 32'h12345678 || rd2[z] !== 32'h12345678) begin
                errors++;
                $display("FAIL stored z=%0d got %h/%h want 12345678", z, rd1[z], rd2[z]);
            end
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        we = 1'b1;
        waddr = 5'd0;
        wdata = 32'hFFFFFFFF;
        issue_en = 1'b1;
        issue_addr = 5'd0;
        raddr1 = 5'd0;
        raddr2 = 5'd0;
        #1;
        checks++;
        if (rd1[1] !== 32'h0 || bs1[1] !== 1'b0 || rd1[0] !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL zero_same_cycle got zr1=%h/%b zr0=%h want 0/0 ffffffff",
                     rd1[1], bs1[1], rd1[0]);
        end
        tick();
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (rd2[1] !== 32'h0 || bs2[1] !== 1'b0) begin
            errors++;
            $display("FAIL zero_reg_zr1 got %h busy %b want 0/0", rd2[1], bs2[1]);
        end
        checks++;
        if (rd2[0] !== 32'hFFFFFFFF || bs2[0] !== 1'b1) begin
            errors++;
            $display("FAIL zero_reg_zr0 got %h busy %b want ffffffff/1", rd2[0], bs2[0]);
        end
        tick();
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        idle();
        issue_en = 1'b1;
        issue_addr = 5'd7;
        raddr1 = 5'd7;
        tick();
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk);
            idle();
            #1;
            checks++;
            if (bs1[1] !== 1'b1 || bs1[0] !== 1'b1) begin
                errors++;
                $display("FAIL busy_after_issue cyc%0d got %b/%b want 1", c, bs1[1], bs1[0]);
            end
            tick();
        end
        @(negedge clk);
        we = 1'b1;
        waddr = 5'd7;
        wdata = 32'hA5A5A5A5;
        #1;
        checks++;
        if (bs1[1] !== 1'b0 || rd1[1] !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL wb_mask got busy %b data %h want 0/a5a5a5a5", bs1[1], rd1[1]);
        end
        tick();
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (bs1[1] !== 1'b0 || rd1[1] !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL wb_retire got busy %b data %h want 0/a5a5a5a5", bs1[1], rd1[1]);
        end
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        idle();
        we = 1'b1;
        waddr = 5'd9;
        wdata = 32'h0BADF00D;
        issue_en = 1'b1;
        issue_addr = 5'd9;
        tick();
        @(negedge clk);
        idle();
        raddr1 = 5'd9;
        #1;
        for (int z = 0; z < 2; z++) begin
            checks++;
            if (bs1[z] !== 1'b1 || rd1[z] !== 32'h0BADF00D) begin
                errors++;
                $display("FAIL issue_wb_same z=%0d got %b/%h want 1/0badf00d",
                         z, bs1[z], rd1[z]);
            end
        end
        issue_en = 1'b1;
        issue_addr = 5'd12;
        tick();
        @(negedge clk);
        idle();
        flush = 1'b1;
        issue_en = 1'b1;
        issue_addr = 5'd10;
        we = 1'b1;
        waddr = 5'd11;
        wdata = 32'hC0FFEE11;
        tick();
        @(negedge clk);
        idle();
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a);
            raddr2 = 5'(a);
            #1;
            checks++;
            if (bs1[1] || bs2[1] || bs1[0] || bs2[0]) begin
                errors++;
                $display("FAIL flush_busy r%0d got %b%b%b%b want 0", a,
                         bs1[1], bs2[1], bs1[0], bs2[0]);
            end
        end
        raddr1 = 5'd11;
        #1;
        checks++;
        if (rd1[1] !== 32'hC0FFEE11 || rd1[0] !== 32'hC0FFEE11) begin
            errors++;
            $display("FAIL flush_write got %h/%h want c0ffee11", rd1[1], rd1[0]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            we = 1'($urandom);
            waddr = 5'($urandom_range(0, 7));
            wdata = $urandom;
            issue_en = 1'($urandom);
            issue_addr = 5'($urandom_range(0, 7));
            flush = ($urandom_range(0, 15) == 0);
            raddr1 = 5'($urandom_range(0, 7));
            raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom);
            #1;
            for (int z = 0; z < 2; z++) begin
                checks++;
                if (rd1[z] !== exp_rd(z, raddr1) || rd2[z] !== exp_rd(z, raddr2) ||
                    bs1[z] !== exp_bs(z, raddr1) || bs2[z] !== exp_bs(z, raddr2)) begin
                    errors++;
                    $display("FAIL random i=%0d z=%0d got %h %h %b %b want %h %h %b %b",
                             i, z, rd1[z], rd2[z], bs1[z], bs2[z],
                             exp_rd(z, raddr1), exp_rd(z, raddr2),
                             exp_bs(z, raddr1), exp_bs(z, raddr2));
                end
            end
            tick();
        end
    endtask

    task automatic test_mid_reset();
        int n1, n0;
        @(negedge clk);
        idle();
        we = 1'b1;
        waddr = 5'd3;
        wdata = 32'h55;
        tick();
        @(negedge clk);
        idle();
        issue_en = 1'b1;
        issue_addr = 5'd3;
        tick();
        @(negedge clk);
        idle();
        raddr1 = 5'd3;
        #1;
        checks++;
        if (bs1[1] !== 1'b1 || rd1[1] !== 32'h55) begin
            errors++;
            $display("FAIL pre_reset got %b/%h want 1/55", bs1[1], rd1[1]);
        end
        #1;
        rst = 1'b1;
        #1;
        for (int z = 0; z < 2; z++) begin
            checks++;
            if (rdy[z] !== 1'b0 || bs1[z] !== 1'b0 || rd1[z] !== 32'h0) begin
                errors++;
                $display("FAIL async_reset z=%0d ready=%b busy=%b data=%h want 0/0/0",
                         z, rdy[z], bs1[z], rd1[z]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        wait_clear(n1, n0);
        checks++;
        if (n1 != 31 || n0 != 32) begin
            errors++;
            $display("FAIL mid_clear_edges got %0d/%0d want 31/32", n1, n0);
        end
        model_clear();
        @(negedge clk);
        idle();
        raddr2 = 5'd3;
        #1;
        for (int z = 0; z < 2; z++) begin
            checks++;
            if (rd2[z] !== 32'h0 || bs2[z] !== 1'b0) begin
                errors++;
                $display("FAIL r3_after_reset z=%0d got %h/%b want 0/0", z, rd2[z], bs2[z]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_simultaneous();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_scoreboard.md
# rf_scoreboard

Parametrised register file for the pipelined CPU with write-to-read bypass, per-register pending (scoreboard) bits, and a hardware clear sequencer. It sits in the decode stage: the read ports feed operands, and the busy flags feed the hazard/stall unit. The writeback port commits results. A flush input drops all pending producers on an interrupt or exception redirect.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries (derived, not overridable)
- ZERO_REG, 1, 1: entry 0 reads 0, ignores writes, is never busy; 0: entry 0 is an ordinary register
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- we  in  1  writeback enable
- waddr  in  ADDR_W  writeback address
- wdata  in  DATA_W  writeback data
- raddr1, raddr2  in  ADDR_W  read addresses
- rdata1, rdata2  out  DATA_W  read data (combinational)
- busy1, busy2  out  1  pending-producer flag for raddr1/raddr2 (combinational)
- issue_en  in  1  an instruction that will write issue_addr has issued
- issue_addr  in  ADDR_W  destination of the issuing instruction
- flush  in  1  clear all busy bits
- ready  out  1  clear sequence complete; block accepts traffic

## Operation
- Storage: DEPTH x DATA_W array with no reset on the array. Busy vector: DEPTH bits, asynchronously reset to 0.
- Clear FSM, states CLEAR and RUN:
  - rst forces state=CLEAR and clr_idx=(ZERO_REG ? 1 : 0).
  - In CLEAR, each edge writes 0 to rf[clr_idx] and increments clr_idx.
  - When clr_idx==DEPTH-1 is written, the next state is RUN.
  - RUN holds until the next rst.
- While in CLEAR:
  - we, issue_en and flush are ignored.
  - rdata* = 0 and busy* = 0.
- Write (RUN): if we and not (ZERO_REG and waddr==0), rf[waddr] <= wdata.
- Read (RUN):
  - rdataN = 0 if ZERO_REG and raddrN==0.
  - Otherwise rdataN = wdata if we and waddr==raddrN (write-first bypass).
  - Otherwise rdataN = rf[raddrN].
- Busy update (RUN), in priority order:
  1. flush: all busy bits <= 0. issue_en is ignored that cycle; the write from we still commits.
  2. issue_en with issue_addr==waddr and we: busy[addr] <= 1 (the new producer wins).
  3. Otherwise: issue_en sets busy[issue_addr]; we clears busy[waddr].
  - With ZERO_REG, busy[0] is never set.
- busyN = busy[raddrN] and not (we and waddr==raddrN). A same-cycle writeback is covered by the bypass.
- Both read ports may target the same address; each resolves independently.
- rst asserted mid-operation: busy clears immediately and ready drops immediately. Array contents are undefined until the clear sequence finishes.

## Timing
- Reset values: ready=0, state=CLEAR, busy=0, rdata*=0, busy*=0.
- ready rises after DEPTH-1 rising edges following rst deassertion (ZERO_REG=1), or DEPTH edges (ZERO_REG=0). Default: 31 edges.
- Write latency: one edge to storage. Data is visible on the read ports in the same cycle via the bypass.
- Scoreboard: issue at edge n makes busy visible from cycle n+1. A writeback in cycle m masks busy combinationally in cycle m; the bit is clear from m+1.
- Read path: purely combinational from raddr*, we, waddr, wdata to rdata*/busy*.

## Test plan
- Reset and clear: pulse rst, count edges until ready=1, expect 31. Before the clear, pre-load garbage by a forced write; after ready, all 32 reads return 0x00000000. A write during CLEAR (waddr=3, 0xDEAD) leaves r3=0.
- Bypass: in one cycle, we=1, waddr=5, wdata=0x12345678, raddr1=raddr2=5. Expect rdata1=rdata2=0x12345678 that cycle and from storage the next cycle.
- Zero register: write 0xFFFFFFFF to r0 and issue to r0. Expect rdata=0 and busy=0. Repeat with ZERO_REG=0 and expect 0xFFFFFFFF and busy set.
- Scoreboard: issue r7 at edge 1, so busy1=1 for raddr1=7. Writeback r7 with 0xA5A5A5A5 in cycle 4: busy1=0 and rdata1=0xA5A5A5A5 in the same cycle.
- Simultaneous events:
  - Issue r9 and writeback r9 in the same cycle: r9 is written and busy[9]=1 afterward.
  - flush with issue r10 and writeback r11 in the same cycle: all busy=0 and r11 is written.
- Reset mid-operation: with busy[3]=1 and r3=0x55, assert rst asynchronously between edges. Expect ready=0 and busy*=0 immediately, a full 31-edge clear, then r3=0.
